// File: rtl/kyber_pkg.sv
// Shared definitions for the Kyber polynomial-RAM arbiter.
//   - default RAM geometry (8 x 12-bit coefficients per word, 512 words)
//   - fixed client index assignments of the datapath sub-blocks
//   - read-return tag carried alongside each RAM port's read latency
package kyber_pkg;
  localparam int DATA_W_DEF = 96;
  localparam int ADDR_W_DEF = 9;
  localparam int CID_W      = 3;   // enough for up to 8 clients

  localparam logic [CID_W-1:0] CID_CBD   = 3'd0;
  localparam logic [CID_W-1:0] CID_A_GEN = 3'd1;
  localparam logic [CID_W-1:0] CID_NTT   = 3'd2;
  localparam logic [CID_W-1:0] CID_CODER = 3'd3;

  typedef struct packed {
    logic             vld;
    logic             dbg;   // return belongs to the debug reader, not a client
    logic [CID_W-1:0] cid;
  } rd_tag_t;
endpackage

// File: rtl/kyber_ram_arbiter_rr_arbiter.sv
// Round-robin picker: grants the first set request at or after ptr,
// wrapping modulo N.
//   req : request vector        ptr : start index
//   gnt : one-hot grant         idx : index of granted bit   any : a grant was made
module rr_arbiter #(
  parameter int N     = 5,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] idx,
  output logic             any
);
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      int j;
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!any && req[j[PTR_W-1:0]]) begin
        any = 1'b1;
        gnt[j[PTR_W-1:0]] = 1'b1;
        idx = j[PTR_W-1:0];
      end
    end
  end
endmodule

// File: rtl/kyber_ram_arbiter.sv
// Dual-port polynomial BRAM arbiter.
// Grants up to two client requests per cycle onto RAM ports A/B (writes first,
// lowest index first; reads round-robin from rr_ptr), reserves port A for the
// debug reader while paused, tags each read so the returned word is routed
// back RD_LATENCY cycles later, flags same-address write collisions and
// counts stall cycles.
//   req/we/addr/wdata : per-client request, flattened client-major
//   gnt               : combinational grant      rvalid/rdata : read returns
//   pause/dbg_*       : debug read path on port A
//   ram_*             : RAM port A/B drive and read data
//   err_collision     : sticky collision flag    stall_count : saturating stall count
module kyber_ram_arbiter
  import kyber_pkg::*;
#(
  parameter int NUM_CLIENTS = 5,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int RD_LATENCY  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic [NUM_CLIENTS-1:0]        req,
  input  logic [NUM_CLIENTS-1:0]        we,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] addr,
  input  logic [NUM_CLIENTS*DATA_W-1:0] wdata,
  output logic [NUM_CLIENTS-1:0]        gnt,
  output logic [NUM_CLIENTS-1:0]        rvalid,
  output logic [NUM_CLIENTS*DATA_W-1:0] rdata,
  input  logic                          pause,
  input  logic [ADDR_W-1:0]             dbg_addr,
  output logic [DATA_W-1:0]             dbg_rdata,
  output logic                          dbg_valid,
  output logic [ADDR_W-1:0]             ram_addr_a,
  output logic [ADDR_W-1:0]             ram_addr_b,
  output logic                          ram_wen_a,
  output logic                          ram_wen_b,
  output logic [DATA_W-1:0]             ram_wdata_a,
  output logic [DATA_W-1:0]             ram_wdata_b,
  input  logic [DATA_W-1:0]             ram_rdata_a,
  input  logic [DATA_W-1:0]             ram_rdata_b,
  output logic                          err_collision,
  output logic [15:0]                   stall_count
);
  localparam int PTR_W = $clog2(NUM_CLIENTS);

  logic [ADDR_W-1:0] cl_addr  [NUM_CLIENTS];
  logic [DATA_W-1:0] cl_wdata [NUM_CLIENTS];

  always_comb begin
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      cl_addr[i]  = addr[i*ADDR_W +: ADDR_W];
      cl_wdata[i] = wdata[i*DATA_W +: DATA_W];
    end
  end

  // ---- picks: two arbiter passes. A pending write always beats reads and
  // uses pointer 0, which turns the round-robin picker into fixed priority.
  logic [NUM_CLIENTS-1:0] wr_req, rd_req, p1_req, p2_req, p1_gnt, p2_gnt, wr_rem;
  logic [PTR_W-1:0]       p1_ptr, p2_ptr, p1_idx, p2_idx, rr_ptr_q, rr_ptr_d;
  logic                   p1_any, p2_any, p1_wr, p2_wr;

  always_comb begin
    wr_req = req & we;
    rd_req = req & ~we;
    p1_wr  = |wr_req;
    p1_req = p1_wr ? wr_req : rd_req;
    p1_ptr = p1_wr ? '0 : rr_ptr_q;
    wr_rem = wr_req & ~p1_gnt;
    p2_wr  = |wr_rem;
    p2_req = p2_wr ? wr_rem : (rd_req & ~p1_gnt);
    p2_ptr = p2_wr ? '0 : rr_ptr_q;
  end

  rr_arbiter #(.N(NUM_CLIENTS), .PTR_W(PTR_W)) u_pick1 (
    .req(p1_req), .ptr(p1_ptr), .gnt(p1_gnt), .idx(p1_idx), .any(p1_any));
  rr_arbiter #(.N(NUM_CLIENTS), .PTR_W(PTR_W)) u_pick2 (
    .req(p2_req), .ptr(p2_ptr), .gnt(p2_gnt), .idx(p2_idx), .any(p2_any));

  // ---- port assignment. While paused only the first pick is served, on B.
  logic             b_vld, b_wr, a_act, collide, stall;
  logic [PTR_W-1:0] b_idx;
  rd_tag_t          tag_a_in, tag_b_in;

  always_comb begin
    b_vld = pause ? p1_any : p2_any;
    b_wr  = pause ? p1_wr  : p2_wr;
    b_idx = pause ? p1_idx : p2_idx;
    gnt   = pause ? p1_gnt : (p1_gnt | p2_gnt);
    a_act = pause | p1_any;

    ram_addr_a = '0; ram_wen_a = 1'b0; ram_wdata_a = '0;
    if (pause) begin
      ram_addr_a = dbg_addr;
    end else if (p1_any) begin
      ram_addr_a  = cl_addr[p1_idx];
      ram_wen_a   = p1_wr;
      ram_wdata_a = p1_wr ? cl_wdata[p1_idx] : '0;
    end

    ram_addr_b = '0; ram_wen_b = 1'b0; ram_wdata_b = '0;
    if (b_vld) begin
      ram_addr_b  = cl_addr[b_idx];
      ram_wen_b   = b_wr;
      ram_wdata_b = b_wr ? cl_wdata[b_idx] : '0;
    end

    // Same word on both ports with any write: port A wins, B's write is
    // dropped but B keeps its grant.
    collide = a_act && b_vld && (ram_addr_a == ram_addr_b) && (ram_wen_a || b_wr);
    if (collide) ram_wen_b = 1'b0;

    stall = |(req & ~gnt);

    tag_a_in.vld = pause | (p1_any & ~p1_wr);
    tag_a_in.dbg = pause;
    tag_a_in.cid = pause ? '0 : CID_W'(p1_idx);
    tag_b_in.vld = b_vld & ~b_wr;
    tag_b_in.dbg = 1'b0;
    tag_b_in.cid = CID_W'(b_idx);
  end

  // ---- round-robin pointer: one past the reader granted last in rotation
  // order (the port-B pick when both picks are reads).
  logic             last_vld;
  logic [PTR_W-1:0] last_idx;
  logic             err_d, err_q;
  logic [15:0]      stall_count_d, stall_count_q;

  always_comb begin
    last_vld = 1'b0;
    last_idx = '0;
    if (!pause && p2_any && !p2_wr) begin
      last_vld = 1'b1; last_idx = p2_idx;
    end else if (p1_any && !p1_wr) begin
      last_vld = 1'b1; last_idx = p1_idx;
    end
    rr_ptr_d = rr_ptr_q;
    if (last_vld)
      rr_ptr_d = (int'(last_idx) == NUM_CLIENTS-1) ? '0 : last_idx + PTR_W'(1);
    err_d         = err_q | collide;
    stall_count_d = (stall && stall_count_q != 16'hFFFF) ? stall_count_q + 16'd1 : stall_count_q;
    if (clear) begin
      rr_ptr_d      = '0;
      err_d         = 1'b0;
      stall_count_d = '0;
    end
  end

  // ---- read tag pipelines, one per port
  rd_tag_t tag_a_d [RD_LATENCY];
  rd_tag_t tag_a_q [RD_LATENCY];
  rd_tag_t tag_b_d [RD_LATENCY];
  rd_tag_t tag_b_q [RD_LATENCY];

  always_comb begin
    tag_a_d[0] = tag_a_in;
    tag_b_d[0] = tag_b_in;
    for (int k = 1; k < RD_LATENCY; k++) begin
      tag_a_d[k] = tag_a_q[k-1];
      tag_b_d[k] = tag_b_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < RD_LATENCY; k++) begin
        tag_a_q[k] <= '0;
        tag_b_q[k] <= '0;
      end
      rr_ptr_q      <= '0;
      err_q         <= 1'b0;
      stall_count_q <= '0;
    end else begin
      tag_a_q       <= tag_a_d;
      tag_b_q       <= tag_b_d;
      rr_ptr_q      <= rr_ptr_d;
      err_q         <= err_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign err_collision = err_q;
  assign stall_count   = stall_count_q;

  // ---- return routing
  rd_tag_t ta, tb;
  always_comb begin
    ta        = tag_a_q[RD_LATENCY-1];
    tb        = tag_b_q[RD_LATENCY-1];
    rvalid    = '0;
    rdata     = '0;
    dbg_valid = ta.vld & ta.dbg;
    dbg_rdata = dbg_valid ? ram_rdata_a : '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (ta.vld && !ta.dbg && ta.cid == CID_W'(i)) begin
        rvalid[i] = 1'b1;
        rdata[i*DATA_W +: DATA_W] = ram_rdata_a;
      end
      if (tb.vld && !tb.dbg && tb.cid == CID_W'(i)) begin
        rvalid[i] = 1'b1;
        rdata[i*DATA_W +: DATA_W] = ram_rdata_b;
      end
    end
  end
endmodule

// File: tb/tb_kyber_ram_arbiter.sv
module tb_kyber_ram_arbiter;
  localparam int N = 5, DW = 96, AW = 9;
  localparam logic [DW-1:0] D0 = 96'hD000_0000_1111_2222_3333_4444;
  localparam logic [DW-1:0] D3 = 96'hD333_5555_6666_7777_8888_9999;
  localparam logic [DW-1:0] DA = 96'hAAAA_0101_0202_0303_0404_0505;
  localparam logic [DW-1:0] DB = 96'hBBBB_0606_0707_0808_0909_0A0A;

  logic clk, rst, clear, pause;
  logic [N-1:0] req, we;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [AW-1:0] dbg_addr;

  // latency-1 instance
  logic [N-1:0] gnt1, rvalid1;
  logic [N*DW-1:0] rdata1;
  logic [DW-1:0] dbg_rdata1, ram1_wdata_a, ram1_wdata_b, ram1_rdata_a, ram1_rdata_b;
  logic dbg_valid1, ram1_wen_a, ram1_wen_b, err1;
  logic [AW-1:0] ram1_addr_a, ram1_addr_b;
  logic [15:0] stall1;
  // latency-3 instance
  logic [N-1:0] gnt3, rvalid3;
  logic [N*DW-1:0] rdata3;
  logic [DW-1:0] dbg_rdata3, ram3_wdata_a, ram3_wdata_b, ram3_rdata_a, ram3_rdata_b;
  logic dbg_valid3, ram3_wen_a, ram3_wen_b, err3;
  logic [AW-1:0] ram3_addr_a, ram3_addr_b;
  logic [15:0] stall3;

  kyber_ram_arbiter #(.NUM_CLIENTS(N), .DATA_W(DW), .ADDR_W(AW), .RD_LATENCY(1)) dut (
    .clk(clk), .rst(rst), .clear(clear), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt1), .rvalid(rvalid1), .rdata(rdata1), .pause(pause), .dbg_addr(dbg_addr),
    .dbg_rdata(dbg_rdata1), .dbg_valid(dbg_valid1),
    .ram_addr_a(ram1_addr_a), .ram_addr_b(ram1_addr_b), .ram_wen_a(ram1_wen_a), .ram_wen_b(ram1_wen_b),
    .ram_wdata_a(ram1_wdata_a), .ram_wdata_b(ram1_wdata_b),
    .ram_rdata_a(ram1_rdata_a), .ram_rdata_b(ram1_rdata_b),
    .err_collision(err1), .stall_count(stall1));

  kyber_ram_arbiter #(.NUM_CLIENTS(N), .DATA_W(DW), .ADDR_W(AW), .RD_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .clear(clear), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt3), .rvalid(rvalid3), .rdata(rdata3), .pause(pause), .dbg_addr(dbg_addr),
    .dbg_rdata(dbg_rdata3), .dbg_valid(dbg_valid3),
    .ram_addr_a(ram3_addr_a), .ram_addr_b(ram3_addr_b), .ram_wen_a(ram3_wen_a), .ram_wen_b(ram3_wen_b),
    .ram_wdata_a(ram3_wdata_a), .ram_wdata_b(ram3_wdata_b),
    .ram_rdata_a(ram3_rdata_a), .ram_rdata_b(ram3_rdata_b),
    .err_collision(err3), .stall_count(stall3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // unwritten words read back a known address-derived pattern
  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {16'hC0DE, 7'h0, a, 64'h0123_4567_89AB_CDEF ^ {55'h0, a}};
  endfunction

  logic [DW-1:0] mem1 [512];
  logic [DW-1:0] mem3 [512];
  logic [511:0]  wf1 = '0;
  logic [511:0]  wf3 = '0;
  logic [DW-1:0] p3a [3];
  logic [DW-1:0] p3b [3];

  always @(posedge clk) begin
    if (ram1_wen_a) begin mem1[ram1_addr_a] <= ram1_wdata_a; wf1[ram1_addr_a] <= 1'b1; end
    if (ram1_wen_b) begin mem1[ram1_addr_b] <= ram1_wdata_b; wf1[ram1_addr_b] <= 1'b1; end
    ram1_rdata_a <= wf1[ram1_addr_a] ? mem1[ram1_addr_a] : pat(ram1_addr_a);
    ram1_rdata_b <= wf1[ram1_addr_b] ? mem1[ram1_addr_b] : pat(ram1_addr_b);
    if (ram3_wen_a) begin mem3[ram3_addr_a] <= ram3_wdata_a; wf3[ram3_addr_a] <= 1'b1; end
    if (ram3_wen_b) begin mem3[ram3_addr_b] <= ram3_wdata_b; wf3[ram3_addr_b] <= 1'b1; end
    p3a[0] <= wf3[ram3_addr_a] ? mem3[ram3_addr_a] : pat(ram3_addr_a);
    p3b[0] <= wf3[ram3_addr_b] ? mem3[ram3_addr_b] : pat(ram3_addr_b);
    p3a[1] <= p3a[0]; p3a[2] <= p3a[1];
    p3b[1] <= p3b[0]; p3b[2] <= p3b[1];
  end
  assign ram3_rdata_a = p3a[2];
  assign ram3_rdata_b = p3b[2];

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    req = '0; we = '0; addr = '0; wdata = '0;
  endtask

  task automatic set_cl(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i] = 1'b1; we[i] = w;
    addr[i*AW +: AW] = a;
    wdata[i*DW +: DW] = d;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  logic [N-1:0] rr_gnt [6];
  logic [AW-1:0] rr_a  [6];
  int cnt [N];

  initial begin
    rr_gnt = '{5'b10010, 5'b10100, 5'b00110, 5'b10010, 5'b10100, 5'b00110};
    rr_a   = '{9'h104, 9'h102, 9'h101, 9'h104, 9'h102, 9'h101};
    rst = 1'b0; clear = 1'b0; pause = 1'b0; dbg_addr = '0; idle();
    repeat (2) @(negedge clk);
    chk("rst_rvalid", rvalid1, 0);
    chk("rst_dbg_valid", dbg_valid1, 0);
    chk("rst_err", err1, 0);
    chk("rst_stall", stall1, 0);
    rst = 1'b1;

    // single reader
    tick(); idle(); set_cl(2, 1'b0, 9'h010, '0);
    @(negedge clk);
    chk("t1_gnt", gnt1, 5'b00100);
    chk("t1_addr_a", ram1_addr_a, 9'h010);
    chk("t1_wen_a", ram1_wen_a, 0);
    chk("t1_idle_b", {ram1_wen_b, ram1_addr_b, ram1_wdata_b}, 0);
    tick(); idle(); @(negedge clk);
    chk("t1_rvalid", rvalid1, 5'b00100);
    chk("t1_rdata", rdata1[2*DW +: DW], pat(9'h010));

    // writes beat reads; readers stall
    for (int k = 0; k < 3; k++) begin
      tick(); idle();
      set_cl(0, 1'b1, 9'h020, D0); set_cl(3, 1'b1, 9'h030, D3);
      set_cl(1, 1'b0, 9'h040, '0); set_cl(4, 1'b0, 9'h041, '0);
      @(negedge clk);
      chk("t2_gnt", gnt1, 5'b01001);
      chk("t2_port_a", {ram1_wen_a, ram1_addr_a, ram1_wdata_a}, {1'b1, 9'h020, D0});
      chk("t2_port_b", {ram1_wen_b, ram1_addr_b, ram1_wdata_b}, {1'b1, 9'h030, D3});
      chk("t2_stall", stall1, 128'(k));
    end
    tick(); idle(); @(negedge clk);
    chk("t2_stall_end", stall1, 3);
    chk("t2_no_rvalid", rvalid1, 0);
    // read back: rr_ptr is 3, so client 4 goes first on port A
    tick(); idle(); set_cl(2, 1'b0, 9'h020, '0); set_cl(4, 1'b0, 9'h030, '0);
    @(negedge clk);
    chk("t2b_gnt", gnt1, 5'b10100);
    chk("t2b_addrs", {ram1_addr_a, ram1_addr_b}, {9'h030, 9'h020});
    tick(); idle(); @(negedge clk);
    chk("t2b_rvalid", rvalid1, 5'b10100);
    chk("t2b_rdata2", rdata1[2*DW +: DW], D0);
    chk("t2b_rdata4", rdata1[4*DW +: DW], D3);

    // round-robin fairness, pointer starts at 3
    for (int i = 0; i < N; i++) cnt[i] = 0;
    for (int c = 0; c < 6; c++) begin
      tick(); idle();
      set_cl(1, 1'b0, 9'h101, '0); set_cl(2, 1'b0, 9'h102, '0); set_cl(4, 1'b0, 9'h104, '0);
      @(negedge clk);
      chk("t3_gnt", gnt1, rr_gnt[c]);
      chk("t3_first", ram1_addr_a, rr_a[c]);
      if (c > 0) chk("t3_rvalid", rvalid1, rr_gnt[c-1]);
      for (int i = 0; i < N; i++) cnt[i] += int'(gnt1[i]);
    end
    tick(); idle(); @(negedge clk);
    chk("t3_rvalid_last", rvalid1, rr_gnt[5]);
    chk("t3_cnt1", cnt[1], 4);
    chk("t3_cnt2", cnt[2], 4);
    chk("t3_cnt4", cnt[4], 4);
    chk("t3_stall", stall1, 9);

    // write collision
    tick(); idle(); set_cl(0, 1'b1, 9'h055, DA); set_cl(1, 1'b1, 9'h055, DB);
    @(negedge clk);
    chk("t4_gnt", gnt1, 5'b00011);
    chk("t4_wen", {ram1_wen_a, ram1_wen_b}, 2'b10);
    chk("t4_addr_b", ram1_addr_b, 9'h055);
    chk("t4_err_pre", err1, 0);
    tick(); idle(); @(negedge clk);
    chk("t4_err", err1, 1);
    tick(); idle(); set_cl(3, 1'b0, 9'h055, '0); @(negedge clk);
    chk("t4_rd_gnt", gnt1, 5'b01000);
    chk("t4_err_hold", err1, 1);
    tick(); idle(); @(negedge clk);
    chk("t4_rvalid", rvalid1, 5'b01000);
    chk("t4_rdata", rdata1[3*DW +: DW], DA);
    // clear together with a stall: clear wins, pointer back to 0
    tick(); idle(); clear = 1'b1;
    set_cl(1, 1'b0, 9'h101, '0); set_cl(2, 1'b0, 9'h102, '0); set_cl(4, 1'b0, 9'h104, '0);
    @(negedge clk);
    chk("t4_clr_gnt", gnt1, 5'b10010);
    tick(); clear = 1'b0; @(negedge clk);
    chk("t4_clr_err", err1, 0);
    chk("t4_clr_stall", stall1, 0);
    chk("t4_clr_ptr", gnt1, 5'b00110);
    tick(); idle(); @(negedge clk);
    chk("t4_stall_again", stall1, 1);
    chk("t5_dbg_idle", {dbg_valid1, dbg_rdata1}, 0);

    // debug pause: port A to debug, one client on B
    tick(); idle(); pause = 1'b1; dbg_addr = 9'h1FF;
    set_cl(2, 1'b0, 9'h0A2, '0); set_cl(4, 1'b0, 9'h0A4, '0);
    @(negedge clk);
    chk("t5_gnt", gnt1, 5'b10000);
    chk("t5_port_a", {ram1_wen_a, ram1_addr_a}, {1'b0, 9'h1FF});
    chk("t5_addr_b", ram1_addr_b, 9'h0A4);
    tick(); @(negedge clk);
    chk("t5_dbg_valid", dbg_valid1, 1);
    chk("t5_dbg_rdata", dbg_rdata1, pat(9'h1FF));
    chk("t5_rvalid", rvalid1, 5'b10000);
    chk("t5_rdata4", rdata1[4*DW +: DW], pat(9'h0A4));
    chk("t5_gnt2", gnt1, 5'b00100);
    tick(); idle(); pause = 1'b0; @(negedge clk);
    chk("t5_dbg_inflight", dbg_valid1, 1);
    chk("t5_rvalid2", rvalid1, 5'b00100);
    tick(); idle(); @(negedge clk);
    chk("t5_dbg_off", {dbg_valid1, dbg_rdata1}, 0);

    // latency 3 instance
    tick(); idle(); set_cl(0, 1'b0, 9'h010, '0); @(negedge clk);
    chk("t6_gnt3", gnt3, 5'b00001);
    tick(); idle(); @(negedge clk);
    chk("t6_lat1", rvalid3, 0);
    tick(); @(negedge clk);
    chk("t6_lat2", rvalid3, 0);
    tick(); @(negedge clk);
    chk("t6_lat3", rvalid3, 5'b00001);
    chk("t6_rdata3", rdata3[0 +: DW], pat(9'h010));

    // reset with reads in flight
    for (int q = 0; q < 3; q++) begin
      tick(); idle(); pause = 1'b1; dbg_addr = 9'h1FF; set_cl(1, 1'b0, 9'h111, '0);
    end
    tick(); idle(); pause = 1'b0;
    chk("t6_pre_rvalid", rvalid3, 5'b00010);
    chk("t6_pre_dbg", dbg_valid3, 1);
    rst = 1'b0; #1;
    chk("t6_rst_rvalid", rvalid3, 0);
    chk("t6_rst_dbg", dbg_valid3, 0);
    chk("t6_rst_stall1", stall1, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int q = 0; q < 4; q++) begin
      tick(); @(negedge clk);
      chk("t6_stale", {rvalid3, dbg_valid3}, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
